// File: rtl/i2c_spi_bridge_ctrl_if.sv
// Byte stream from the I2C receiver on one side, the SPI controller pins and status on the other.
// The bridge uses the slave modport; whoever feeds it bytes and plays the SPI target uses master.
interface i2c_spi_bridge_ctrl_if;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       is_addr_byte;
    logic       bus_active;
    logic       spi_miso;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic [7:0] miso_byte;
    logic       miso_valid;
    logic       busy;
    logic       overflow;

    modport master (
        output rx_byte, byte_valid, is_addr_byte, bus_active, spi_miso,
        input  spi_sck, spi_mosi, spi_cs_n, miso_byte, miso_valid, busy, overflow
    );

    modport slave (
        input  rx_byte, byte_valid, is_addr_byte, bus_active, spi_miso,
        output spi_sck, spi_mosi, spi_cs_n, miso_byte, miso_valid, busy, overflow
    );
endinterface

// File: rtl/i2c_spi_bridge_ctrl.sv
// Replays received I2C bytes as SPI mode-0 frames: an address byte opens a chip-select frame,
// data bytes stream into the open frame, and a small FIFO absorbs bytes that arrive mid-shift.
module i2c_spi_bridge_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int FIFO_AW = 2
) (
    input logic                  clk,
    input logic                  rst,
    i2c_spi_bridge_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DW    = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

    state_t             state, state_nx;
    logic [8:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, empty, push, pop, load, div_done, data_head;
    logic [8:0]         head;

    logic [DW-1:0] div_cnt, div_nx;
    logic [2:0]    bit_cnt, bit_nx;
    logic [7:0]    tx_byte, tx_nx, rx_shift, rxs_nx, miso_byte, mbyte_nx;
    logic          sck, sck_nx, mosi, mosi_nx, cs_n, cs_n_nx, mvalid, mvalid_nx, busy, overflow;

    assign full      = (count == (FIFO_AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign push      = bus.byte_valid && !full;
    assign head      = mem[rd_ptr];
    assign data_head = !empty && !head[8];
    assign div_done  = (div_cnt == DIV_LAST);

    // NOTE: every variable written below gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        div_nx    = div_cnt;
        bit_nx    = bit_cnt;
        tx_nx     = tx_byte;
        rxs_nx    = rx_shift;
        sck_nx    = sck;
        mosi_nx   = mosi;
        cs_n_nx   = cs_n;
        mbyte_nx  = miso_byte;
        mvalid_nx = 1'b0;
        load      = 1'b0;
        pop       = 1'b0;
        unique case (state)
            IDLE: load = !empty;
            SHIFT_LO: begin
                if (div_done) begin
                    sck_nx   = 1'b1;
                    rxs_nx   = {rx_shift[6:0], bus.spi_miso};
                    div_nx   = '0;
                    state_nx = SHIFT_HI;
                end else begin
                    div_nx = div_cnt + DW'(1);
                end
            end
            SHIFT_HI: begin
                if (div_done) begin
                    sck_nx = 1'b0;
                    div_nx = '0;
                    if (bit_cnt != 3'd0) begin
                        bit_nx   = bit_cnt - 3'd1;
                        mosi_nx  = tx_byte[bit_cnt - 3'd1];
                        state_nx = SHIFT_LO;
                    end else begin
                        mbyte_nx  = rx_shift;
                        mvalid_nx = 1'b1;
                        load      = data_head;
                        if (!data_head)
                            state_nx = HOLD;
                    end
                end else begin
                    div_nx = div_cnt + DW'(1);
                end
            end
            HOLD: begin
                if (data_head) begin
                    load = 1'b1;
                end else if (!empty || !bus.bus_active) begin
                    // An address byte waiting, or the I2C transaction ended: close the frame.
                    if (div_done) begin
                        cs_n_nx  = 1'b1;
                        div_nx   = '0;
                        state_nx = GAP;
                    end else begin
                        div_nx = div_cnt + DW'(1);
                    end
                end else begin
                    div_nx = '0;
                end
            end
            GAP: begin
                if (div_done) begin
                    div_nx = '0;
                    load   = !empty;
                    if (empty)
                        state_nx = IDLE;
                end else begin
                    div_nx = div_cnt + DW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        // Popping from the end of GAP keeps the CS-high gap between frames at exactly CLK_DIV.
        if (load) begin
            pop      = 1'b1;
            cs_n_nx  = 1'b0;
            tx_nx    = head[7:0];
            mosi_nx  = head[7];
            bit_nx   = 3'd7;
            div_nx   = '0;
            state_nx = SHIFT_LO;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= 3'd7;
            tx_byte   <= '0;
            rx_shift  <= '0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= 1'b1;
            miso_byte <= '0;
            mvalid    <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_nx;
            div_cnt   <= div_nx;
            bit_cnt   <= bit_nx;
            tx_byte   <= tx_nx;
            rx_shift  <= rxs_nx;
            sck       <= sck_nx;
            mosi      <= mosi_nx;
            cs_n      <= cs_n_nx;
            miso_byte <= mbyte_nx;
            mvalid    <= mvalid_nx;
            busy      <= !cs_n || !empty;
            if (bus.byte_valid && full)
                overflow <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

    // NOTE: FIFO storage has no reset; the cleared pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.is_addr_byte, bus.rx_byte};
    end

    assign bus.spi_sck    = sck;
    assign bus.spi_mosi   = mosi;
    assign bus.spi_cs_n   = cs_n;
    assign bus.miso_byte  = miso_byte;
    assign bus.miso_valid = mvalid;
    assign bus.busy       = busy;
    assign bus.overflow   = overflow;
endmodule

// File: doc/i2c_spi_bridge_ctrl.md
# i2c_spi_bridge_ctrl

Downstream stage of the I2C peripheral receiver. It consumes received bytes (`rx_byte`, `byte_valid`, `is_addr_byte`, `bus_active`) and replays them as SPI mode-0 controller frames: the register-address byte opens a chip-select frame, and following data bytes stream in the same frame. A small FIFO absorbs bytes that arrive while the shifter is busy.

## Interface
- `CLK_DIV`, 4: SCK half-period in `clk` cycles; legal range 1..255; 0 is illegal.
- `FIFO_AW`, 2: FIFO address width; depth = 2^FIFO_AW entries of 9 bits `{is_addr, byte}`.

- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rx_byte`  in  8  byte from the I2C receiver.
- `byte_valid`  in  1  one-cycle strobe; `rx_byte` is valid in that cycle.
- `is_addr_byte`  in  1  qualifies `rx_byte` as a register-address byte.
- `bus_active`  in  1  high between I2C START and STOP.
- `spi_miso`  in  1  SPI data from the target.
- `spi_sck`  out  1  SPI clock, idle low.
- `spi_mosi`  out  1  SPI data, MSB first.
- `spi_cs_n`  out  1  chip select, active low.
- `miso_byte`  out  8  last full byte shifted in from `spi_miso`.
- `miso_valid`  out  1  one-cycle pulse when `miso_byte` updates.
- `busy`  out  1  high when `spi_cs_n` is low or the FIFO is non-empty.
- `overflow`  out  1  sticky flag, set when a byte is dropped on a full FIFO.

## Operation
- **FIFO push:** occurs on `byte_valid` when the FIFO is not full.
  - Full FIFO: the byte is dropped and `overflow` is set.
  - `overflow` clears only on `rst`.
  - A simultaneous push and pop on a full FIFO is still a drop. The full flag is evaluated before the pop.
- **States:** IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP. A `div_cnt` counts 0..CLK_DIV-1 and a `bit_cnt` counts 7..0.
- **IDLE** (`spi_cs_n`=1, `spi_sck`=0):
  - On FIFO non-empty: pop the head, whether it is an addr or data entry.
  - Drive `spi_cs_n`=0 and `spi_mosi`=bit7, then go to SHIFT_LO.
  - A data entry with no open frame also opens a frame.
- **SHIFT_LO:**
  - `spi_sck`=0 for CLK_DIV cycles.
  - Then `spi_sck`←1, sample `spi_miso` into the RX shifter, go to SHIFT_HI.
- **SHIFT_HI:** `spi_sck`=1 for CLK_DIV cycles, then `spi_sck`←0.
  - If `bit_cnt`>0: drive the next bit on `spi_mosi`, go to SHIFT_LO.
  - If `bit_cnt`=0: load `miso_byte`, pulse `miso_valid`, then:
    - FIFO head is a data entry: pop it, drive its bit7 in the same cycle, go to SHIFT_LO (no CS gap).
    - Otherwise: go to HOLD.
- **HOLD** (`spi_cs_n`=0, `spi_sck`=0), evaluated every cycle:
  - Data entry present: pop and continue as above.
  - Addr entry present, or (FIFO empty and `bus_active`=0): wait CLK_DIV cycles, then `spi_cs_n`←1 and go to GAP.
  - Otherwise: stay in HOLD. The frame stays open across slow I2C bytes.
- **GAP:** `spi_cs_n`=1 for CLK_DIV cycles, then IDLE. A repeated START therefore produces a new CS frame.
- **`rst`:** asserted at any time, including mid-frame, it immediately forces:
  - IDLE and a cleared FIFO;
  - `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0;
  - `miso_byte`=0, `miso_valid`=0, `busy`=0, `overflow`=0.

## Timing
- All outputs are registered.
- **Push to frame start:** push at edge E (`byte_valid` in cycle T). `spi_cs_n` falls and `spi_mosi`=bit7 at edge E+1 (visible in cycle T+2).
- **Per-bit and per-byte timing:**
  - Each bit lasts 2·CLK_DIV cycles.
  - One byte lasts 16·CLK_DIV cycles, from the first SCK-low phase to the final falling SCK.
  - CS-low to first SCK rise: CLK_DIV cycles.
- **SPI mode 0:** MOSI changes only on SCK falling or at frame start. MISO is sampled on SCK rising.
- **Frame close:**
  - Last SCK fall to CS rise: ≥CLK_DIV cycles.
  - CS high between frames: exactly CLK_DIV cycles after a close.
- **Back-to-back data bytes:** no extra cycles between the last bit of a byte and the first bit of the next.
- `miso_valid` is asserted in the cycle after the 8th SCK falling edge, together with the new `miso_byte`.
- `busy` updates one cycle after the FIFO or CS change.

## Test plan
- **Single write** (CLK_DIV=2): push addr 0x12, then data 0xA5, `bus_active` drops after the push.
  - Expect one CS frame of 16 SCK pulses, with MOSI carrying 0x12 then 0xA5 MSB first.
  - Expect CS high ≥2 cycles after the last fall.
  - Expect `busy` to return to 0.
- **Slow data** (CLK_DIV=1): push addr 0x40, then data 0x01 300 cycles later with `bus_active` held high.
  - Expect CS to stay low throughout and no SCK in the idle interval.
- **Repeated START:** addr 0x10, data 0x55, addr 0x20, data 0xAA.
  - Expect two CS frames separated by CS high for exactly CLK_DIV cycles, carrying 0x10,0x55 | 0x20,0xAA.
- **Overflow** (FIFO_AW=2, CLK_DIV=8): push 6 bytes on consecutive cycles.
  - Expect the first 5 transmitted: 1 popped immediately plus 4 buffered.
  - Expect the 6th dropped and `overflow`=1 until `rst`.
- **MISO loopback** (`spi_miso`=`spi_mosi`): send 0xC3.
  - Expect `miso_valid` pulsing once with `miso_byte`=0xC3 after the 8th SCK fall.
- **Reset mid-frame:** assert `rst` during bit 4 of a byte.
  - Expect next cycle: `spi_cs_n`=1, `spi_sck`=0, `busy`=0, FIFO empty.
  - Expect a subsequent transaction to run cleanly.
